servo_pwm_gen: RTL

//  Two-channel servo PWM generator; the pulse-producing stage directly downstream of
//  the Wishbone servo register block. It consumes that block's period (T0/T1) and

---
 rtl/servo_pwm_gen_if.sv | 27 ++
 rtl/servo_pwm_gen.sv | 86 ++++++++
 2 files changed

// File: rtl/servo_pwm_gen_if.sv
// Servo PWM bus bundle: period/high-time registers flowing from the register
// block towards the PWM generator, and the pins/wrap strobes coming back.
interface servo_pwm_gen_if #(
   parameter int TW = 23,
   parameter int DW = 18
);
   logic [TW-1:0] T0;
   logic [DW-1:0] D0;
   logic [TW-1:0] T1;
   logic [DW-1:0] D1;
   logic          servo0;
   logic          servo1;
   logic          wrap0;
   logic          wrap1;

   // Register block side: supplies period and high time, observes outputs.
   modport master (
      output T0, D0, T1, D1,
      input  servo0, servo1, wrap0, wrap1
   );

   // PWM generator side.
   modport slave (
      input  T0, D0, T1, D1,
      output servo0, servo1, wrap0, wrap1
   );
endinterface

// File: rtl/servo_pwm_gen.sv
// Two-channel servo PWM generator. Each channel latches its period/high time
// into shadow registers only at period wrap (or every cycle while disabled),
// so register writes never truncate or stretch a pulse in flight.
module servo_pwm_gen #(
   parameter int TW = 23,
   parameter int DW = 18
) (
   input  logic            clk,
   input  logic            resetn,
   servo_pwm_gen_if.slave  bus
);

   logic [TW-1:0] t_in    [2];
   logic [DW-1:0] d_in    [2];
   logic          servo_q [2];
   logic          wrap_q  [2];

   assign t_in[0]    = bus.T0;
   assign d_in[0]    = bus.D0;
   assign t_in[1]    = bus.T1;
   assign d_in[1]    = bus.D1;
   assign bus.servo0 = servo_q[0];
   assign bus.servo1 = servo_q[1];
   assign bus.wrap0  = wrap_q[0];
   assign bus.wrap1  = wrap_q[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         logic [TW-1:0] cnt_reg, cnt_next;
         logic [TW-1:0] ts_reg, ts_next;
         logic [DW-1:0] ds_reg, ds_next;
         logic          servo_reg, servo_next;
         logic          wrap_reg, wrap_next;
         logic          last_cycle;

         // cnt < Ts always holds while running, so Ts-1 cannot underflow here.
         assign last_cycle = (cnt_reg == ts_reg - TW'(1));

         // Next-state: hold disabled and track inputs, or count and reload at wrap.
         always_comb begin
            cnt_next   = cnt_reg;
            ts_next    = ts_reg;
            ds_next    = ds_reg;
            servo_next = 1'b0;
            wrap_next  = 1'b0;
            if (ts_reg == '0) begin
               cnt_next = '0;
               ts_next  = t_in[gi];
               ds_next  = d_in[gi];
            end else begin
               // Output lags the counter by one cycle; high for exactly Ds counts.
               servo_next = (TW'(ds_reg) > cnt_reg);
               if (last_cycle) begin
                  cnt_next  = '0;
                  ts_next   = t_in[gi];
                  ds_next   = d_in[gi];
                  wrap_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + TW'(1);
               end
            end
         end

         // State register; asynchronous reset drops the pin immediately.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               cnt_reg   <= '0;
               ts_reg    <= '0;
               ds_reg    <= '0;
               servo_reg <= 1'b0;
               wrap_reg  <= 1'b0;
            end else begin
               cnt_reg   <= cnt_next;
               ts_reg    <= ts_next;
               ds_reg    <= ds_next;
               servo_reg <= servo_next;
               wrap_reg  <= wrap_next;
            end
         end

         assign servo_q[gi] = servo_reg;
         assign wrap_q[gi]  = wrap_reg;
      end
   endgenerate

endmodule
